// File: rtl/enc_link_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : enc_link_decoder_if
// Purpose  : Handshake bundle between the 8-to-3 encoder side (producer),
//            the receive FIFO/decoder and its consumer.
// Ports    : put_code/EN_put/RDY_put  - producer write channel
//            EN_get/RDY_get/get_onehot - consumer read channel
//            level, rcv_count, err_drop - status
// Modports : master - drives put_code, EN_put, EN_get (producer/consumer side)
//            slave  - the decoder itself
// Revision : 1.0 - initial release
// ============================================================================
interface enc_link_decoder_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic [2:0]               put_code;
  logic                     EN_put;
  logic                     RDY_put;
  logic                     EN_get;
  logic                     RDY_get;
  logic [7:0]               get_onehot;
  logic [$clog2(DEPTH):0]   level;
  logic [CNT_W-1:0]         rcv_count;
  logic                     err_drop;

  modport master (
    output put_code, EN_put, EN_get,
    input  RDY_put, RDY_get, get_onehot, level, rcv_count, err_drop
  );

  modport slave (
    input  put_code, EN_put, EN_get,
    output RDY_put, RDY_get, get_onehot, level, rcv_count, err_drop
  );
endinterface
`default_nettype wire

// File: rtl/enc_link_decoder.sv
`default_nettype none
// ============================================================================
// Module   : enc_link_decoder
// Purpose  : Receive stage of the encoded link. Buffers 3-bit codes in a
//            DEPTH-entry FIFO and presents the head entry decoded to an
//            8-bit one-hot word. Keeps a saturating delivered-word counter
//            and a sticky overflow flag.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - enc_link_decoder_if.slave (put/get handshakes + status)
// Revision : 1.0 - initial release
// ============================================================================
module enc_link_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  wire                 clk,
  input  wire                 rst,
  enc_link_decoder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic             w_rdy_put;
  logic             w_rdy_get;
  logic             w_put;
  logic             w_get;

  // Ready flags depend only on registered occupancy, so there is no
  // combinational path from the strobes to any output.
  assign w_rdy_put = (r_level != LW'(DEPTH));
  assign w_rdy_get = (r_level != '0);
  assign w_put     = bus.EN_put & w_rdy_put;
  assign w_get     = bus.EN_get & w_rdy_get;

  // Storage array is never reset: stale entries are unreachable once the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (w_put) begin
      r_mem[r_wp] <= bus.put_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide, so they wrap naturally.
      if (w_put) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_get) begin
        r_rp <= r_rp + 1'b1;
        if (r_count != {CNT_W{1'b1}}) begin
          r_count <= r_count + 1'b1;
        end
      end
      case ({w_put, w_get})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // Any put attempt while full loses a code; remember it until reset.
      if (bus.EN_put && !w_rdy_put) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.RDY_put    = w_rdy_put;
  assign bus.RDY_get    = w_rdy_get;
  assign bus.get_onehot = w_rdy_get ? (8'h01 << r_mem[r_rp]) : 8'h00;
  assign bus.level      = r_level;
  assign bus.rcv_count  = r_count;
  assign bus.err_drop   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_enc_link_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_link_decoder
// Purpose  : Self-checking bench for enc_link_decoder (DEPTH=4, CNT_W=4).
//            A queue-based reference model tracks the stored codes, the
//            delivered count and the overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_link_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enc_link_decoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  enc_link_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model
  int q[$];
  int m_cnt = 0;
  bit m_err = 1'b0;

  // Observed/expected status vectors:
  // {RDY_put, RDY_get, get_onehot[7:0], level[2:0], rcv_count[3:0], err_drop}
  function automatic logic [17:0] obs();
    return {bus.RDY_put, bus.RDY_get, bus.get_onehot, bus.level,
            bus.rcv_count, bus.err_drop};
  endfunction

  function automatic logic [17:0] expv();
    logic [7:0] oh;
    int n;
    n  = q.size();
    oh = (n > 0) ? 8'(1 << q[0]) : 8'h00;
    return {(n != DEPTH), (n != 0), oh, 3'(n), 4'(m_cnt), m_err};
  endfunction

  // One clock of stimulus; returns at posedge+1 with the model updated.
  task automatic step(input bit p, input logic [2:0] c, input bit g);
    bit acc_p;
    bit acc_g;
    @(negedge clk);
    bus.EN_put   = p;
    bus.put_code = c;
    bus.EN_get   = g;
    acc_p = p && (q.size() < DEPTH);
    acc_g = g && (q.size() > 0);
    if (p && !acc_p) m_err = 1'b1;
    @(posedge clk);
    if (acc_g) begin
      void'(q.pop_front());
      m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
    end
    if (acc_p) q.push_back(int'(c));
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    bus.EN_put   = 1'b0;
    bus.EN_get   = 1'b0;
    bus.put_code = 3'd0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    q.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL reset_initial: got %h want %h", obs(), expv());
    end
    rst = 1'b0;
    step(1, 3'd1, 0);
    step(1, 3'd4, 0);
    step(1, 3'd6, 0);
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL reset_prefill: got %h want %h", obs(), expv());
    end
    // Assert reset away from any edge, with a put still being driven.
    @(negedge clk);
    bus.EN_put = 1'b1;
    #1;
    rst = 1'b1;
    q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    #1;
    total++;
    if (obs() !== {1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_async: got %h want %h", obs(),
               {1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0});
    end
    bus.EN_put = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_order_decode();
    logic [2:0] codes [4];
    logic [7:0] want  [4];
    codes = '{3'd7, 3'd5, 3'd0, 3'd3};
    want  = '{8'h80, 8'h20, 8'h01, 8'h08};
    reset_dut();
    for (int i = 0; i < 4; i++) step(1, codes[i], 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.get_onehot !== want[i] || obs() !== expv()) begin
        bad++;
        $display("FAIL order_decode[%0d]: got %h/%h want %h/%h", i,
                 bus.get_onehot, obs(), want[i], expv());
      end
      step(0, 3'd0, 1);
    end
    total++;
    if (bus.rcv_count !== 4'd4 || bus.level !== 3'd0 || obs() !== expv()) begin
      bad++;
      $display("FAIL order_final: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 4; i++) step(1, 3'd2, 0);
    total++;
    if (bus.RDY_put !== 1'b0 || bus.err_drop !== 1'b0 || obs() !== expv()) begin
      bad++;
      $display("FAIL overflow_full: got %h want %h", obs(), expv());
    end
    step(1, 3'd6, 0);
    total++;
    if (bus.err_drop !== 1'b1 || bus.level !== 3'd4 || obs() !== expv()) begin
      bad++;
      $display("FAIL overflow_drop: got %h want %h", obs(), expv());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.get_onehot !== 8'h04 || obs() !== expv()) begin
        bad++;
        $display("FAIL overflow_get[%0d]: got %h want %h", i, obs(), expv());
      end
      step(0, 3'd0, 1);
    end
    step(1, 3'd1, 0);
    step(0, 3'd0, 1);
    total++;
    if (bus.err_drop !== 1'b1 || obs() !== expv()) begin
      bad++;
      $display("FAIL overflow_sticky: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    for (int i = 0; i < 4; i++) step(1, 3'(i + 1), 0);
    step(1, 3'd7, 1);
    total++;
    if (bus.level !== 3'd3 || bus.get_onehot !== 8'h04 || bus.err_drop !== 1'b1
        || obs() !== expv()) begin
      bad++;
      $display("FAIL simul_full: got %h want %h", obs(), expv());
    end
    for (int i = 0; i < 3; i++) step(0, 3'd0, 1);
    total++;
    if (bus.get_onehot !== 8'h00 || bus.RDY_get !== 1'b0 || obs() !== expv()) begin
      bad++;
      $display("FAIL simul_empty_pre: got %h want %h", obs(), expv());
    end
    step(1, 3'd5, 1);
    total++;
    if (bus.level !== 3'd1 || bus.get_onehot !== 8'h20 || bus.rcv_count !== 4'd4
        || obs() !== expv()) begin
      bad++;
      $display("FAIL simul_empty_post: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    step(1, 3'd0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 3'(i % 8), 1);
      total++;
      if (bus.level !== 3'd1 || bus.get_onehot !== 8'(1 << (i % 8))
          || obs() !== expv()) begin
        bad++;
        $display("FAIL stream[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 4));
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    step(1, 3'd3, 0);
    for (int i = 0; i < 17; i++) step(1, 3'($urandom_range(0, 7)), 1);
    total++;
    if (bus.rcv_count !== 4'hF || obs() !== expv()) begin
      bad++;
      $display("FAIL saturation: got %h want %h", obs(), expv());
    end
  endtask

  initial begin
    bus.EN_put   = 1'b0;
    bus.EN_get   = 1'b0;
    bus.put_code = 3'd0;
    rst = 1'b1;
    #12;
    test_reset();
    test_order_decode();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/enc_link_decoder.md
# enc_link_decoder

Receive-side stage of the encoded transmission link: accepts 3-bit codes produced by the 8-to-3 encoder, buffers them in a small FIFO, and presents each code decoded back to an 8-bit one-hot word. Sits directly downstream of the encoder and decouples producer and consumer through ready/enable handshakes. Also maintains a saturating delivered-word counter and a sticky overflow flag.

## Interface
- DEPTH, 4, FIFO depth in entries; power of two, minimum 2
- CNT_W, 16, width of the delivered-word counter
- CLK  input  1  sole clock, rising-edge active
- RST  input  1  reset, asynchronous, active-high
- put_code  input  3  encoded value (a2,a1,a0) from the encoder
- EN_put  input  1  producer write strobe, honoured only when RDY_put=1
- RDY_put  output  1  FIFO can accept a code this cycle
- EN_get  input  1  consumer read strobe, honoured only when RDY_get=1
- RDY_get  output  1  FIFO holds at least one code
- get_onehot  output  8  one-hot decode of the head entry (bit n set for code n)
- level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- rcv_count  output  CNT_W  number of accepted gets, saturating
- err_drop  output  1  sticky: a put was attempted while full

## Operation
- Storage: DEPTH x 3-bit register array, write pointer wp, read pointer rp (log2(DEPTH) bits, wrap naturally), occupancy register level.
- RDY_put = (level != DEPTH); RDY_get = (level != 0); both combinational from registered state.
- get_onehot = 8'h01 << mem[rp] when RDY_get=1, else 8'h00.
- Accepted put (EN_put & RDY_put): mem[wp] <= put_code, wp <= wp+1.
- Accepted get (EN_get & RDY_get): rp <= rp+1; rcv_count <= rcv_count+1 unless already all-ones (saturate, no wrap).
- level: +1 on put-only, -1 on get-only, unchanged on put+get or neither.
- Full with EN_put and EN_get both high: only get is honoured (RDY_put=0); level DEPTH -> DEPTH-1; put_code discarded and err_drop set.
- Empty with both high: only put honoured; level 0 -> 1; no bypass, nothing delivered this cycle.
- err_drop: set on any cycle with EN_put=1 and RDY_put=0; cleared only by RST.
- EN_get while empty: no effect, no error.
- Pointer wrap: wp/rp roll from DEPTH-1 to 0; ordering is strict FIFO across wrap.

## Timing
- Reset (async assert, any cycle, including mid-transfer): wp=rp=0, level=0, rcv_count=0, err_drop=0; outputs immediately RDY_put=1, RDY_get=0, get_onehot=8'h00. Stored contents discarded; array need not be cleared.
- Deassertion of RST takes effect at the next CLK edge; first put accepted on that edge if EN_put=1.
- Latency: code accepted at edge N appears on get_onehot with RDY_get=1 after edge N (visible during cycle N+1) when FIFO was empty.
- Throughput: one put and one get per cycle sustained when 0 < level < DEPTH.
- All outputs change only on CLK edges or RST assertion; no combinational path from EN_put/EN_get/put_code to any output.

## Test plan
- Reset check: assert RST mid-stream with level=3 -> RDY_put=1, RDY_get=0, get_onehot=0, level=0, rcv_count=0, err_drop=0 without a clock edge.
- Order/decode: put codes 7,5,0,3 back-to-back, then get x4 -> get_onehot 8'h80, 8'h20, 8'h01, 8'h08; rcv_count=4; level returns 0.
- Full/overflow: 4 puts (code 2) then 5th put code 6 -> RDY_put=0 after 4th, 5th dropped, err_drop=1 and stays 1 through later traffic; gets return 8'h04 x4.
- Simultaneous at full: level=4, EN_put=EN_get=1 -> level=3, head advances, err_drop=1; at empty with both high -> level=1, get_onehot=0 that cycle, value of put visible next cycle.
- Wrap/streaming: 20 cycles of concurrent put+get of incrementing codes mod 8 after one pre-fill -> outputs match inputs delayed one entry, level constant 1, pointers wrap without loss.
- Counter saturation (CNT_W=4): 17 accepted gets -> rcv_count holds 4'hF.
